// File: rtl/button_pkg.sv
// Shared state encoding and time-to-cycle helpers for the button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } btn_state_t;

    function automatic int ms_to_cyc(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

    // Width of a counter that must hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_ch.sv
// One button channel: synchroniser, debounce FSM, and hold timer that
// produces long-press and auto-repeat pulses.
module button_conditioner_ch
    import button_pkg::*;
#(
    parameter int STABLE_CYC = 20,
    parameter int LONG_CYC   = 100,
    parameter int REPEAT_CYC = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int HOLD_MAX = (REPEAT_CYC > 0) ? (LONG_CYC + REPEAT_CYC - 1) : LONG_CYC;
    localparam int STAB_W   = cnt_width(STABLE_CYC);
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'((STABLE_CYC > 1) ? (STABLE_CYC - 1) : 0);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_VAL  = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_MAX);

    logic              sync_meta;
    logic              sync_q;
    btn_state_t        state_q;
    btn_state_t        state_d;
    logic [STAB_W-1:0] stab_q;
    logic [STAB_W-1:0] stab_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              level_d;
    logic              press_d;
    logic              release_d;
    logic              long_d;
    logic              repeat_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RELEASED;
            stab_q  <= '0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
        end
    end

    // The sample that leaves a settled state counts as the first stable sample.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        case (state_q)
            RELEASED: begin
                if (sync_q) begin
                    if (STABLE_CYC <= 1) begin
                        state_d = PRESSED;
                        stab_d  = '0;
                    end else begin
                        state_d = CONFIRM_PRESS;
                        stab_d  = STAB_W'(1);
                    end
                end
            end
            CONFIRM_PRESS: begin
                if (!sync_q) begin
                    state_d = RELEASED;
                    stab_d  = '0;
                end else if (stab_q >= STAB_LAST) begin
                    state_d = PRESSED;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            PRESSED: begin
                if (!sync_q) begin
                    if (STABLE_CYC <= 1) begin
                        state_d = RELEASED;
                        stab_d  = '0;
                    end else begin
                        state_d = CONFIRM_RELEASE;
                        stab_d  = STAB_W'(1);
                    end
                end
            end
            CONFIRM_RELEASE: begin
                if (sync_q) begin
                    state_d = PRESSED;
                    stab_d  = '0;
                end else if (stab_q >= STAB_LAST) begin
                    state_d = RELEASED;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                stab_d  = '0;
            end
        endcase
    end

    // Hold timer runs only while the button stays down across an edge; after
    // the long press it cycles between LONG_CYC and HOLD_TOP so it never wraps.
    always_comb begin
        level_d   = (state_d == PRESSED) || (state_d == CONFIRM_RELEASE);
        press_d   = level_d && !level;
        release_d = !level_d && level;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        hold_d    = hold_q;
        if (!level_d || !level) begin
            hold_d = '0;
        end else if (hold_q == LONG_LAST) begin
            long_d = 1'b1;
            hold_d = LONG_VAL;
        end else if ((REPEAT_CYC > 0) && (hold_q == HOLD_TOP)) begin
            repeat_d = 1'b1;
            hold_d   = LONG_VAL;
        end else if (hold_q != HOLD_TOP) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q        <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            hold_q        <= hold_d;
            level         <= level_d;
            press         <= press_d;
            release_pulse <= release_d;
            long_press    <= long_d;
            repeat_pulse  <= repeat_d;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: per-channel polarity fix-up, then an
// independent debounce / long-press / auto-repeat channel for each button.
module button_conditioner
    import button_pkg::*;
#(
    parameter int                CLK_FREQ        = 100_000_000,
    parameter int                NUM_CH          = 5,
    parameter int                STABLE_TIME_MS  = 20,
    parameter int                LONG_PRESS_MS   = 1000,
    parameter int                REPEAT_MS       = 200,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] button_in,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] long_press,
    output logic [NUM_CH-1:0] repeat_pulse
);

    localparam int STABLE_CYC = ms_to_cyc(CLK_FREQ, STABLE_TIME_MS);
    localparam int LONG_CYC   = ms_to_cyc(CLK_FREQ, LONG_PRESS_MS);
    localparam int REPEAT_CYC = ms_to_cyc(CLK_FREQ, REPEAT_MS);

    logic [NUM_CH-1:0] btn_norm;

    assign btn_norm = button_in ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        button_conditioner_ch #(
            .STABLE_CYC (STABLE_CYC),
            .LONG_CYC   (LONG_CYC),
            .REPEAT_CYC (REPEAT_CYC)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .btn           (btn_norm[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: 1 kHz clock so 1 ms = 1 cycle
// (stable 20, long 100, repeat 30), channel 3 wired active-low.
module tb_button_conditioner;

    localparam int NCH = 4;
    localparam logic [NCH-1:0] IDLE = 4'b1000;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] button_in;
    logic [NCH-1:0] level;
    logic [NCH-1:0] press;
    logic [NCH-1:0] release_pulse;
    logic [NCH-1:0] long_press;
    logic [NCH-1:0] repeat_pulse;

    int checks = 0;
    int errors = 0;

    int press_cnt   [NCH];
    int press_first [NCH];
    int press_last  [NCH];
    int rel_cnt     [NCH];
    int rel_first   [NCH];
    int long_cnt    [NCH];
    int long_first  [NCH];
    int rep_cnt     [NCH];
    int rep_first   [NCH];
    int rep_last    [NCH];
    int level_first [NCH];
    int both_cnt = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .CLK_FREQ        (1000),
        .NUM_CH          (NCH),
        .STABLE_TIME_MS  (20),
        .LONG_PRESS_MS   (100),
        .REPEAT_MS       (30),
        .ACTIVE_LOW_MASK (4'b1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button_in     (button_in),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] v);
        button_in = v;
    endtask

    task automatic clearStats();
        for (int c = 0; c < NCH; c++) begin
            press_cnt[c]   = 0;
            press_first[c] = 0;
            press_last[c]  = 0;
            rel_cnt[c]     = 0;
            rel_first[c]   = 0;
            long_cnt[c]    = 0;
            long_first[c]  = 0;
            rep_cnt[c]     = 0;
            rep_first[c]   = 0;
            rep_last[c]    = 0;
            level_first[c] = 0;
        end
    endtask

    // Logs which relative edge each pulse was seen on, per channel.
    task automatic observeEdge(input int k);
        for (int c = 0; c < NCH; c++) begin
            if (press[c]) begin
                press_cnt[c]++;
                if (press_first[c] == 0) press_first[c] = k;
                press_last[c] = k;
            end
            if (release_pulse[c]) begin
                rel_cnt[c]++;
                if (rel_first[c] == 0) rel_first[c] = k;
            end
            if (long_press[c]) begin
                long_cnt[c]++;
                if (long_first[c] == 0) long_first[c] = k;
            end
            if (repeat_pulse[c]) begin
                rep_cnt[c]++;
                if (rep_first[c] == 0) rep_first[c] = k;
                rep_last[c] = k;
            end
            if (level[c] && level_first[c] == 0) level_first[c] = k;
            if (press[c] && release_pulse[c]) both_cnt++;
        end
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        applyStimulus(IDLE);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ch0 held, ch1 chatters, ch2 aborted then real press, ch3 active-low held.
    function automatic logic [NCH-1:0] vecA(input int k);
        logic [NCH-1:0] v;
        v[0] = 1'b1;
        v[1] = (k <= 50) && (k % 2 == 1);
        v[2] = (k <= 19) || (k >= 21 && k <= 60);
        v[3] = 1'b0;
        return v;
    endfunction

    // ch0 short hold then release, ch2 held with a short glitch low.
    function automatic logic [NCH-1:0] vecB(input int k);
        logic [NCH-1:0] v;
        v    = IDLE;
        v[0] = (k <= 71);
        v[2] = !(k >= 50 && k <= 54);
        return v;
    endfunction

    initial begin
        reset     = 1'b1;
        button_in = IDLE;
        doReset(3);
        checkOutput("rst_level",   int'(level), 0);
        checkOutput("rst_press",   int'(press), 0);
        checkOutput("rst_release", int'(release_pulse), 0);
        checkOutput("rst_long",    int'(long_press), 0);
        checkOutput("rst_repeat",  int'(repeat_pulse), 0);

        clearStats();
        for (int k = 1; k <= 200; k++) begin
            applyStimulus(vecA(k));
            @(posedge clk);
            #1;
            observeEdge(k);
        end
        checkOutput("A_press0_edge",  press_first[0], 22);
        checkOutput("A_press0_cnt",   press_cnt[0], 1);
        checkOutput("A_level0_edge",  level_first[0], 22);
        checkOutput("A_long0_edge",   long_first[0], 122);
        checkOutput("A_long0_cnt",    long_cnt[0], 1);
        checkOutput("A_rep0_first",   rep_first[0], 152);
        checkOutput("A_rep0_last",    rep_last[0], 182);
        checkOutput("A_rep0_cnt",     rep_cnt[0], 2);
        checkOutput("A_rel0_cnt",     rel_cnt[0], 0);
        checkOutput("A_press1_cnt",   press_cnt[1], 0);
        checkOutput("A_level1_edge",  level_first[1], 0);
        checkOutput("A_press2_edge",  press_first[2], 42);
        checkOutput("A_press2_cnt",   press_cnt[2], 1);
        checkOutput("A_rel2_edge",    rel_first[2], 82);
        checkOutput("A_long2_cnt",    long_cnt[2], 0);
        checkOutput("A_press3_edge",  press_first[3], 22);
        checkOutput("A_press3_cnt",   press_cnt[3], 1);

        doReset(2);
        clearStats();
        for (int k = 1; k <= 200; k++) begin
            applyStimulus(vecB(k));
            @(posedge clk);
            #1;
            observeEdge(k);
        end
        checkOutput("B_rel0_edge",   rel_first[0], 93);
        checkOutput("B_rel0_cnt",    rel_cnt[0], 1);
        checkOutput("B_long0_cnt",   long_cnt[0], 0);
        checkOutput("B_rep0_cnt",    rep_cnt[0], 0);
        checkOutput("B_level0_end",  int'(level[0]), 0);
        checkOutput("B_press2_cnt",  press_cnt[2], 1);
        checkOutput("B_rel2_cnt",    rel_cnt[2], 0);
        checkOutput("B_long2_edge",  long_first[2], 122);
        checkOutput("B_rep2_edge",   rep_first[2], 152);
        checkOutput("B_press1_cnt",  press_cnt[1], 0);
        checkOutput("B_press3_cnt",  press_cnt[3], 0);

        doReset(2);
        clearStats();
        for (int k = 1; k <= 200; k++) begin
            applyStimulus(4'b1001);
            reset = (k == 83) || (k == 84);
            @(posedge clk);
            #1;
            observeEdge(k);
            if (k == 83) begin
                checkOutput("C_rst_level",   int'(level), 0);
                checkOutput("C_rst_press",   int'(press), 0);
                checkOutput("C_rst_release", int'(release_pulse), 0);
                checkOutput("C_rst_long",    int'(long_press), 0);
                checkOutput("C_rst_repeat",  int'(repeat_pulse), 0);
            end
        end
        reset = 1'b0;
        checkOutput("C_press0_first", press_first[0], 22);
        checkOutput("C_press0_again", press_last[0], 106);
        checkOutput("C_press0_cnt",   press_cnt[0], 2);
        checkOutput("C_rel0_cnt",     rel_cnt[0], 0);
        checkOutput("C_long0_cnt",    long_cnt[0], 0);

        checkOutput("press_release_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter NUM_CH, default 5, number of independent button channels (1..32).
REQ-003 SHALL have parameter STABLE_TIME_MS, default 20, debounce stability window.
REQ-004 SHALL have parameter LONG_PRESS_MS, default 1000, hold time before long-press event (must be >0).
REQ-005 SHALL have parameter REPEAT_MS, default 200, auto-repeat period after long press; 0 disables repeat.
REQ-006 SHALL have parameter ACTIVE_LOW_MASK, default all zeros, [NUM_CH-1:0]; bit set = channel input inverted before synchronisation.
REQ-007 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port button_in, input, NUM_CH, raw asynchronous button levels.
REQ-010 SHALL have port level, output, NUM_CH, debounced pressed state.
REQ-011 SHALL have port press, output, NUM_CH, one-cycle pulse on debounced press.
REQ-012 SHALL have port release, output, NUM_CH, one-cycle pulse on debounced release.
REQ-013 SHALL have port long_press, output, NUM_CH, one-cycle pulse when hold reaches LONG_PRESS_MS.
REQ-014 SHALL have port repeat, output, NUM_CH, one-cycle pulse every REPEAT_MS after long_press while held.

Function
REQ-015 Cycle constants SHALL be STABLE_CYC=(CLK_FREQ/1000)*STABLE_TIME_MS, LONG_CYC and REPEAT_CYC likewise; counter widths via $clog2(max+1).
REQ-016 Each channel SHALL pass through a 2-flop synchroniser after optional inversion; channels fully independent.
REQ-017 Per-channel FSM states SHALL be RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-018 RELEASED->CONFIRM_PRESS when synced input=1; CONFIRM_PRESS->RELEASED when synced input=0 (counter cleared, no pulse).
REQ-019 CONFIRM_PRESS->PRESSED after STABLE_CYC consecutive samples of 1, counted from the RELEASED->CONFIRM_PRESS sample inclusive; same edge sets level=1 and press=1.
REQ-020 PRESSED/CONFIRM_RELEASE mirror REQ-018/019 with opposite polarity; exit sets level=0 and release=1.
REQ-021 Latency: input stable high from edge 1 SHALL give level=1 and press=1 registered at edge STABLE_CYC+2.
REQ-022 Hold counter SHALL start at 0 on the press edge and count while level=1 (including CONFIRM_RELEASE); long_press=1 at edge press+LONG_CYC.
REQ-023 If REPEAT_CYC>0, repeat=1 at edges press+LONG_CYC+n*REPEAT_CYC, n>=1, while level=1; repeat never coincides with long_press.
REQ-024 Release before LONG_CYC SHALL emit no long_press; release SHALL clear hold counter; a bounce aborted in CONFIRM_RELEASE SHALL not reset hold counter.
REQ-025 Hold counter SHALL not wrap: with REPEAT disabled it saturates at LONG_CYC.
REQ-026 All outputs SHALL be registered; press and release never high in the same cycle on one channel.

Reset
REQ-027 On reset: synchronisers, counters cleared; FSM=RELEASED; level, press, release, long_press, repeat all 0, on the next edge.
REQ-028 Reset mid-press SHALL emit no release pulse; a still-held button re-qualifies through the full STABLE_CYC window.

Structure
REQ-029 Shared package button_pkg SHALL hold FSM state encoding and ms-to-cycle conversion function.
REQ-030 Per-channel logic SHALL be sub-module button_conditioner_ch, instantiated NUM_CH times via generate.

Verification (CLK_FREQ=1000, STABLE=20, LONG=100, REPEAT=30, NUM_CH=4)
REQ-031 Ch0 held high from edge 1 -> level[0]/press[0] at edge 22, long_press at edge 122, repeat at 152, 182.
REQ-032 Ch1 toggles 1 cycle high/1 low for 50 cycles then low -> no press, level[1] stays 0.
REQ-033 Ch2 high 19 cycles, low 1, high 40 -> single press at 20 cycles after the restart sample; no earlier pulse.
REQ-034 Ch0 pressed, released after 50 cycles held -> release pulse after STABLE_CYC, no long_press/repeat.
REQ-035 ACTIVE_LOW_MASK=4'b1000, ch3 driven 0 -> press[3] at edge 22; other channels unaffected.
REQ-036 Reset asserted at hold cycle 60 then released with input high -> all outputs 0, no release, press again 22 edges later.
